// File: rtl/mmio_fifo_pkg.sv
// mmio_fifo_pkg: MMIO FIFO addresses, default geometry and status CSR layout
package mmio_fifo_pkg;
    localparam logic [15:0] MMIO_FIFO_DATA_ADDR = 16'h0020;
    localparam logic [15:0] MMIO_FIFO_STAT_ADDR = 16'h0022;
    localparam int MMIO_FIFO_DATA_W = 64;
    localparam int MMIO_FIFO_DEPTH = 8;
    localparam int MMIO_FIFO_CNT_W = $clog2(MMIO_FIFO_DEPTH) + 1;
    typedef struct packed {
        logic [MMIO_FIFO_CNT_W-1:0] count;
        logic full;
        logic empty;
        logic ovf_err;
        logic udf_err;
    } t_mmio_fifo_status;
    function automatic logic [63:0] mmio_fifo_status_word(t_mmio_fifo_status s);
        return 64'(s);
    endfunction
endpackage

// File: rtl/mmio_fifo_stage_fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage, one write port, registered read port zeroed on empty reads
module fifo_ram
    import mmio_fifo_pkg::*;
#(
    parameter int DATA_W = MMIO_FIFO_DATA_W,
    parameter int DEPTH = MMIO_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= rd_zero ? '0 : mem[raddr];
    end
endmodule

// File: rtl/mmio_fifo_stage.sv
// mmio_fifo_stage: MMIO host-to-AFU FIFO with registered pop; MMIO_FIFO_STICKY_ERR_EN adds sticky ovf/udf flags
module mmio_fifo_stage
    import mmio_fifo_pkg::*;
#(
    parameter int DATA_W = MMIO_FIFO_DATA_W,
    parameter int DEPTH = MMIO_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              udf_err,
    input  logic              err_clr
);
    localparam int CNT_W = PTR_W + 1;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign push_ready = ~full;
    assign push_ok = push_valid & ~full;
    assign pop_ok = pop_req & ~empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            pop_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_ok);
            rd_ptr <= rd_ptr + PTR_W'(pop_ok);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            pop_valid <= pop_req;
        end
    end
    fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk(clk),
        .rst(rst),
        .we(push_ok),
        .waddr(wr_ptr),
        .wdata(push_data),
        .re(pop_req),
        .rd_zero(empty),
        .raddr(rd_ptr),
        .rdata(pop_data)
    );
`ifdef MMIO_FIFO_STICKY_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= (push_valid & full) | (ovf_err & ~err_clr);
            udf_err <= (pop_req & empty) | (udf_err & ~err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_fifo_stage.sv
// tb_mmio_fifo_stage: directed table-driven and sequence checks of mmio_fifo_stage
module tb_mmio_fifo_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic [63:0] push_data = '0;
    logic        push_ready;
    logic        pop_req = 1'b0;
    logic [63:0] pop_data;
    logic        pop_valid;
    logic [3:0]  count;
    logic        full, empty, ovf_err, udf_err;
    logic        err_clr = 1'b0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic r, pv;
        logic [63:0] pd;
        logic pr, ec;
        logic epv;
        logic [63:0] epd;
        logic [3:0] ecnt;
        logic eovf, eudf;
    } vec_t;
    vec_t vecs[$];
    logic [63:0] model[$];
    mmio_fifo_stage dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_req(pop_req), .pop_data(pop_data),
        .pop_valid(pop_valid), .count(count), .full(full), .empty(empty),
        .ovf_err(ovf_err), .udf_err(udf_err), .err_clr(err_clr)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] dw(int i);
        return 64'hDA7A_0000_0000_0000 | 64'(i);
    endfunction
    function automatic void add(logic r, logic pv, logic [63:0] pd, logic pr, logic ec,
                                logic epv, logic [63:0] epd, logic [3:0] ecnt, logic eovf, logic eudf);
        vec_t v;
        v.r = r; v.pv = pv; v.pd = pd; v.pr = pr; v.ec = ec;
        v.epv = epv; v.epd = epd; v.ecnt = ecnt; v.eovf = eovf; v.eudf = eudf;
        vecs.push_back(v);
    endfunction
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_err(string name, logic act, logic exp_sticky);
`ifdef MMIO_FIFO_STICKY_ERR_EN
        chk(name, 64'(act), 64'(exp_sticky));
`else
        chk(name, 64'(act), 64'(1'b0 & exp_sticky));
`endif
    endtask
    task automatic step(logic r, logic pv, logic [63:0] pd, logic pr, logic ec);
        rst = r; push_valid = pv; push_data = pd; pop_req = pr; err_clr = ec;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_state(string tag, logic [3:0] ecnt);
        chk({tag, ".count"}, 64'(count), 64'(ecnt));
        chk({tag, ".full"}, 64'(full), 64'(ecnt == 4'd8));
        chk({tag, ".empty"}, 64'(empty), 64'(ecnt == 4'd0));
        chk({tag, ".push_ready"}, 64'(push_ready), 64'(ecnt != 4'd8));
    endtask
    localparam logic [63:0] Z = 64'hDEAD_BEEF_0000_005A;
    localparam logic [63:0] X = 64'h0123_4567_89AB_CDEF;
    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, dw(i), 0, 0, 0, 0, 4'(i), 0, 0);
        add(0, 1, Z, 0, 0, 0, 0, 8, 1, 0);
        add(0, 1, Z, 0, 0, 0, 0, 8, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 0, 0, 1, 0, 1, dw(i), 4'(8 - i), 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, X, 1, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, X, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < vecs.size(); k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            step(vecs[k].r, vecs[k].pv, vecs[k].pd, vecs[k].pr, vecs[k].ec);
            chk_state(tag, vecs[k].ecnt);
            chk({tag, ".pop_valid"}, 64'(pop_valid), 64'(vecs[k].epv));
            if (vecs[k].epv) chk({tag, ".pop_data"}, pop_data, vecs[k].epd);
            chk_err({tag, ".ovf_err"}, ovf_err, vecs[k].eovf);
            chk_err({tag, ".udf_err"}, udf_err, vecs[k].eudf);
        end
        for (int i = 0; i < 3; i++) begin
            model.push_back(dw(100 + i));
            step(0, 1, dw(100 + i), 0, 0);
        end
        chk_state("wrap.fill", 3);
        for (int k = 0; k < 20; k++) begin
            logic [63:0] exp_d;
            exp_d = model.pop_front();
            model.push_back(dw(200 + k));
            step(0, 1, dw(200 + k), 1, 0);
            chk_state($sformatf("wrap%0d", k), 3);
            chk($sformatf("wrap%0d.pop_data", k), pop_data, exp_d);
            chk($sformatf("wrap%0d.pop_valid", k), 64'(pop_valid), 64'(1));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("drain%0d.pop_data", k), pop_data, model.pop_front());
        end
        chk_state("drain", 0);
        for (int i = 0; i < 5; i++) step(0, 1, dw(300 + i), 0, 0);
        chk_state("pre_rst", 5);
        step(1, 0, 0, 1, 0);
        chk("rst.pop_valid", 64'(pop_valid), 64'(0));
        chk("rst.pop_data", pop_data, 64'(0));
        chk_state("rst", 0);
        chk_err("rst.ovf_err", ovf_err, 1'b0);
        chk_err("rst.udf_err", udf_err, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("post_rst.pop_valid", 64'(pop_valid), 64'(1));
        chk("post_rst.pop_data", pop_data, 64'(0));
        chk_state("post_rst", 0);
        step(0, 0, 0, 0, 0);
        chk("idle.pop_valid", 64'(pop_valid), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
